// File: rtl/otprom_cell_ctrl_if.sv
// Request/response bundle between a RAM-style requester and the OTP ROM controller.
interface otprom_cell_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] m_ram_raddr;
  logic              m_ram_ren;
  logic [ADDR_W-1:0] m_ram_waddr;
  logic [DATA_W-1:0] m_ram_wdata;
  logic              m_ram_wen;
  logic [DATA_W-1:0] m_ram_rdata;
  logic              m_ram_rvalid;
  logic              m_ram_rerr;
  logic              m_ram_wdone;
  logic              m_ram_werr;
  logic              busy;
  logic              locked;

  modport master (
    output m_ram_raddr, m_ram_ren, m_ram_waddr, m_ram_wdata, m_ram_wen,
    input  m_ram_rdata, m_ram_rvalid, m_ram_rerr, m_ram_wdone, m_ram_werr, busy, locked
  );

  modport slave (
    input  m_ram_raddr, m_ram_ren, m_ram_waddr, m_ram_wdata, m_ram_wen,
    output m_ram_rdata, m_ram_rvalid, m_ram_rerr, m_ram_wdone, m_ram_werr, busy, locked
  );
endinterface

// File: rtl/otprom_cell_ctrl.sv
// One-time-programmable ROM array and controller: timed reads, OR-only program
// pulses with verify, lock word at the top address and out-of-range reporting.
module otprom_cell_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned READ_LAT    = 2,
  parameter int unsigned PROG_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  otprom_cell_ctrl_if.slave  ram
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_MAX = (READ_LAT > PROG_CYCLES) ? READ_LAT : PROG_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, READ, PROG, VERIFY, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              oor_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] exp_q;
  logic              werr_pend;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              rerr_q;
  logic              wdone_q;
  logic              werr_q;
  logic              prog_fire_c;
  logic              locked_c;

  // Non-volatile storage: deliberately outside the reset domain.
  logic [DATA_W-1:0] cells [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(DEPTH);
  endfunction

  assign locked_c    = cells[DEPTH-1][0];
  assign prog_fire_c = (state == PROG) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (prog_fire_c) cells[idx_q] <= cells[idx_q] | wdata_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      wdata_q   <= '0;
      exp_q     <= '0;
      werr_pend <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      rerr_q    <= 1'b0;
      wdone_q   <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      wdone_q  <= 1'b0;
      werr_q   <= 1'b0;
      case (state)
        IDLE: begin
          // Read has priority; a simultaneous write is dropped.
          if (ram.m_ram_ren) begin
            idx_q <= ram.m_ram_raddr[IDX_W-1:0];
            oor_q <= !in_range(ram.m_ram_raddr);
            cnt   <= CNT_W'(READ_LAT - 1);
            state <= READ;
          end else if (ram.m_ram_wen) begin
            idx_q   <= ram.m_ram_waddr[IDX_W-1:0];
            oor_q   <= !in_range(ram.m_ram_waddr);
            wdata_q <= ram.m_ram_wdata;
            cnt     <= CNT_W'(PROG_CYCLES - 1);
            if (!in_range(ram.m_ram_waddr) || locked_c) begin
              werr_pend <= 1'b1;
              state     <= DONE;
            end else begin
              werr_pend <= 1'b0;
              state     <= PROG;
            end
          end
        end
        READ: begin
          if (cnt == '0) begin
            rvalid_q <= 1'b1;
            rerr_q   <= oor_q;
            rdata_q  <= oor_q ? '0 : cells[idx_q];
            state    <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PROG: begin
          if (cnt == '0) begin
            exp_q <= cells[idx_q] | wdata_q;
            state <= VERIFY;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        VERIFY: begin
          werr_pend <= (cells[idx_q] != exp_q);
          state     <= DONE;
        end
        DONE: begin
          wdone_q <= 1'b1;
          werr_q  <= werr_pend;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ram.m_ram_rdata  = rdata_q;
  assign ram.m_ram_rvalid = rvalid_q;
  assign ram.m_ram_rerr   = rerr_q;
  assign ram.m_ram_wdone  = wdone_q;
  assign ram.m_ram_werr   = werr_q;
  assign ram.busy         = (state != IDLE);
  assign ram.locked       = locked_c;

endmodule

// File: tb/tb_otprom_cell_ctrl.sv
// Scoreboard bench for otprom_cell_ctrl: directed cases plus random traffic
// checked against an array model of the OTP contents and lock state.
module tb_otprom_cell_ctrl;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DEPTH       = 256;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned READ_LAT    = 2;
  localparam int unsigned PROG_CYCLES = 8;

  typedef struct {
    bit          is_read;
    logic [31:0] data;
    bit          err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  bit          locked_m = 1'b0;

  otprom_cell_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut_if ();

  otprom_cell_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .READ_LAT(READ_LAT), .PROG_CYCLES(PROG_CYCLES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ram(dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pops the oldest expectation; late ones are flagged.
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if ((dut_if.m_ram_rerr && !dut_if.m_ram_rvalid) || (dut_if.m_ram_werr && !dut_if.m_ram_wdone))
        chk("stray_err_pulse", 1, 0);
      if (dut_if.m_ram_rvalid || dut_if.m_ram_wdone) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {dut_if.m_ram_rvalid, dut_if.m_ram_wdone}, 0);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          chk("resp_kind", {dut_if.m_ram_rvalid, dut_if.m_ram_wdone}, e.is_read ? 2'b10 : 2'b01);
          if (e.is_read) begin
            chk("rdata", dut_if.m_ram_rdata, e.data);
            chk("rerr", dut_if.m_ram_rerr, e.err);
          end else begin
            chk("werr", dut_if.m_ram_werr, e.err);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("resp_overdue", 64'(cyc), 64'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (dut_if.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (dut_if.busy) chk("busy_timeout", 1, 0);
  endtask

  // All issue tasks start and end on a negedge.
  task automatic issue(input bit ren, input logic [31:0] ra, input bit wen,
                       input logic [31:0] wa, input logic [31:0] wd);
    dut_if.m_ram_ren   = ren;
    dut_if.m_ram_raddr = ra;
    dut_if.m_ram_wen   = wen;
    dut_if.m_ram_waddr = wa;
    dut_if.m_ram_wdata = wd;
    @(posedge clk);
    #1;
    dut_if.m_ram_ren = 1'b0;
    dut_if.m_ram_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_read(input logic [31:0] a);
    exp_t e;
    e.is_read = 1'b1;
    e.err     = (a >= DEPTH);
    e.data    = e.err ? 32'h0 : mem_m[a[7:0]];
    e.due     = cyc + 1 + int'(READ_LAT);
    sb.push_back(e);
  endtask

  task automatic do_read(input logic [31:0] a);
    wait_idle();
    push_read(a);
    issue(1'b1, a, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    wait_idle();
    e.is_read = 1'b0;
    e.data    = 32'h0;
    if (a >= DEPTH || locked_m) begin
      e.err = 1'b1;
      e.due = cyc + 2;
    end else begin
      mem_m[a[7:0]] = mem_m[a[7:0]] | d;
      if (a == DEPTH - 1 && d[0]) locked_m = 1'b1;
      e.err = 1'b0;
      e.due = cyc + 1 + int'(PROG_CYCLES) + 2;
    end
    sb.push_back(e);
    issue(1'b0, 32'h0, 1'b1, a, d);
  endtask

  task automatic do_both(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d);
    wait_idle();
    push_read(ra);
    issue(1'b1, ra, 1'b1, wa, d);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_ops(input int n);
    int unsigned op;
    logic [31:0] a;
    logic [31:0] wa;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 300))
                                       : 32'($urandom_range(0, DEPTH - 2));
      wa = 32'($urandom_range(0, DEPTH - 2));
      d  = $urandom;
      case (op)
        0, 1: do_read(a);
        2:    do_write(a, d);
        default: do_both(a, wa, d);
      endcase
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < int'(DEPTH); i++) mem_m[i] = 32'h0;
    dut_if.m_ram_ren   = 1'b0;
    dut_if.m_ram_wen   = 1'b0;
    dut_if.m_ram_raddr = '0;
    dut_if.m_ram_waddr = '0;
    dut_if.m_ram_wdata = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_busy", dut_if.busy, 0);
    chk("reset_rdata", dut_if.m_ram_rdata, 0);
    chk("reset_locked", dut_if.locked, 0);

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (dut_if.busy || dut_if.m_ram_rvalid || dut_if.m_ram_wdone) bad++;
    end
    chk("idle_quiet", 64'(bad), 0);

    do_read(32'h10);
    do_write(32'h10, 32'h0000_00F0);
    do_write(32'h10, 32'h0000_000F);
    do_read(32'h10);
    do_write(32'h10, 32'h0);
    do_read(32'h10);

    do_read(32'h100);
    do_write(32'h100, 32'hFFFF_FFFF);
    do_read(32'h0);

    do_both(32'h10, 32'h30, 32'h1234_5678);
    do_read(32'h30);

    random_ops(80);

    // Reset early in a program pulse: no completion, cell untouched.
    wait_idle();
    issue(1'b0, 32'h0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    pulse_reset();
    chk("midprog_busy", dut_if.busy, 0);
    chk("midprog_rdata", dut_if.m_ram_rdata, 0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (dut_if.m_ram_wdone) bad++;
    end
    chk("midprog_no_wdone", 64'(bad), 0);
    do_read(32'h40);

    do_write(32'(DEPTH - 1), 32'h1);
    wait_idle();
    chk("locked_set", dut_if.locked, locked_m);
    do_write(32'h20, 32'hAAAA_AAAA);
    do_read(32'h20);
    wait_idle();
    @(negedge clk);
    pulse_reset();
    chk("locked_after_reset", dut_if.locked, 1);
    do_write(32'(DEPTH - 1), 32'hFFFF_FFFF);
    do_read(32'(DEPTH - 1));
    random_ops(40);

    wait_idle();
    repeat (60) begin
      if (sb.size() != 0) @(negedge clk);
    end
    chk("sb_drained", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
